// File: rtl/i2c_reg_responder_pkg.sv
// Shared tag/width macros, FSM encodings and bit-order helpers for the I2C register responder.
// Pure definitions: no latency, no backpressure.
`ifndef I2C_DATA_BITS
`define I2C_DATA_BITS 6
`endif
`ifndef A_ADDR
`define A_ADDR 2'b01
`endif
`ifndef D_ADDR
`define D_ADDR 2'b10
`endif
`define I2C_ST_IDLE     3'd0
`define I2C_ST_ADDR     3'd1
`define I2C_ST_ADDR_ACK 3'd2
`define I2C_ST_WR_BYTE  3'd3
`define I2C_ST_WR_ACK   3'd4
`define I2C_ST_RD_BYTE  3'd5
`define I2C_ST_RD_ACK   3'd6
`define I2C_ST_IGNORE   3'd7

package i2c_reg_responder_pkg;

    typedef logic [`I2C_DATA_BITS-1:0] reg_t;

    typedef enum logic [2:0] {
        ST_IDLE     = `I2C_ST_IDLE,
        ST_ADDR     = `I2C_ST_ADDR,
        ST_ADDR_ACK = `I2C_ST_ADDR_ACK,
        ST_WR_BYTE  = `I2C_ST_WR_BYTE,
        ST_WR_ACK   = `I2C_ST_WR_ACK,
        ST_RD_BYTE  = `I2C_ST_RD_BYTE,
        ST_RD_ACK   = `I2C_ST_RD_ACK,
        ST_IGNORE   = `I2C_ST_IGNORE
    } state_t;

    // Position within a byte of the n-th bit on the wire.
    function automatic logic [2:0] bit_index(input logic [2:0] n, input bit lsb_first);
        return lsb_first ? n : (3'd7 - n);
    endfunction

    function automatic reg_t reg_inc(input reg_t a);
        return a + reg_t'(1);
    endfunction

endpackage

// File: rtl/i2c_reg_responder_line_sync.sv
// Two-flop synchronizer for SCL/SDA with edge pulses and START/STOP detection.
// Events appear 2 CLK after the pad change; no backpressure.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic       scl_prev;
    logic       sda_prev;
    logic       scl;

    // Reset to the idle-bus level so release never fakes an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[0], scl_in};
            sda_sync <= {sda_sync[0], sda_in};
            scl_prev <= scl_sync[1];
            sda_prev <= sda_sync[1];
        end
    end

    assign scl      = scl_sync[1];
    assign sda      = sda_sync[1];
    assign scl_rise = scl & ~scl_prev;
    assign scl_fall = ~scl & scl_prev;
    assign start    = scl & scl_prev & sda_prev & ~sda;
    assign stop     = scl & scl_prev & ~sda_prev & sda;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target decoding tagged write bytes into register pointer loads / writes, serving auto-increment reads.
// Strobes within 3 CLK of the 8th SCL rise; no clock stretching, REG_RDATA expected the CLK after RD_STRB.
module i2c_reg_responder
    import i2c_reg_responder_pkg::*;
#(
    parameter logic [7:0] I2C_ADDR     = 8'h82,
    parameter bit         RX_LSB_FIRST = 1'b1,
    parameter bit         TX_LSB_FIRST = 1'b0
) (
    input  logic                      CLK,
    input  logic                      GSRn,
    input  logic                      SCL_IN,
    input  logic                      SDA_IN,
    output logic                      SDA_OE,
    output logic                      BUSY,
    output logic [`I2C_DATA_BITS-1:0] REG_ADDR,
    output logic                      WR_STRB,
    output logic [`I2C_DATA_BITS-1:0] REG_WDATA,
    output logic                      RD_STRB,
    input  logic [`I2C_DATA_BITS-1:0] REG_RDATA
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] rx;
    logic [7:0] rx_next;
    logic [7:0] tx;
    logic [7:0] load_byte;
    logic       rw;
    logic       ack_phase;

    i2c_line_sync u_line_sync (
        .clk      (CLK),
        .rst_n    (GSRn),
        .scl_in   (SCL_IN),
        .sda_in   (SDA_IN),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    always_comb begin
        rx_next = rx;
        rx_next[bit_index(bit_cnt, RX_LSB_FIRST)] = sda;
    end

    assign load_byte = {`D_ADDR, REG_RDATA};

    always_ff @(posedge CLK or negedge GSRn) begin
        if (!GSRn) begin
            state     <= ST_IDLE;
            bit_cnt   <= 3'd0;
            rx        <= 8'd0;
            tx        <= 8'd0;
            rw        <= 1'b0;
            ack_phase <= 1'b0;
            SDA_OE    <= 1'b0;
            BUSY      <= 1'b0;
            REG_ADDR  <= '0;
            WR_STRB   <= 1'b0;
            REG_WDATA <= '0;
            RD_STRB   <= 1'b0;
        end else begin
            WR_STRB <= 1'b0;
            RD_STRB <= 1'b0;
            if (WR_STRB)
                REG_ADDR <= reg_inc(REG_ADDR);
            // Read data lands the CLK after the request; the first bit goes out immediately.
            if (RD_STRB) begin
                tx     <= load_byte;
                SDA_OE <= ~load_byte[bit_index(3'd0, TX_LSB_FIRST)];
            end

            if (stop) begin
                state  <= ST_IDLE;
                BUSY   <= 1'b0;
                SDA_OE <= 1'b0;
            end else if (start) begin
                state     <= ST_ADDR;
                bit_cnt   <= 3'd0;
                ack_phase <= 1'b0;
                BUSY      <= 1'b1;
                SDA_OE    <= 1'b0;
            end else begin
                case (state)
                    ST_ADDR: begin
                        if (scl_rise) begin
                            rx      <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                if (rx_next[7:1] == I2C_ADDR[7:1]) begin
                                    state     <= ST_ADDR_ACK;
                                    rw        <= rx_next[0];
                                    ack_phase <= 1'b0;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end
                    end
                    ST_ADDR_ACK, ST_WR_ACK: begin
                        if (scl_fall) begin
                            if (!ack_phase) begin
                                SDA_OE    <= 1'b1;
                                ack_phase <= 1'b1;
                            end else begin
                                SDA_OE    <= 1'b0;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                                if (state == ST_ADDR_ACK && rw) begin
                                    RD_STRB <= 1'b1;
                                    state   <= ST_RD_BYTE;
                                end else begin
                                    state <= ST_WR_BYTE;
                                end
                            end
                        end
                    end
                    ST_WR_BYTE: begin
                        if (scl_rise) begin
                            rx      <= rx_next;
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                state     <= ST_WR_ACK;
                                ack_phase <= 1'b0;
                                if (rx_next[7:6] == `A_ADDR) begin
                                    REG_ADDR <= rx_next[5:0];
                                end else if (rx_next[7:6] == `D_ADDR) begin
                                    WR_STRB   <= 1'b1;
                                    REG_WDATA <= rx_next[5:0];
                                end
                            end
                        end
                    end
                    ST_RD_BYTE: begin
                        if (scl_fall) begin
                            if (bit_cnt == 3'd7) begin
                                SDA_OE    <= 1'b0;
                                state     <= ST_RD_ACK;
                                ack_phase <= 1'b0;
                                bit_cnt   <= 3'd0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                SDA_OE  <= ~tx[bit_index(bit_cnt + 3'd1, TX_LSB_FIRST)];
                            end
                        end
                    end
                    ST_RD_ACK: begin
                        // ack_phase marks a master ACK seen, waiting for the low phase to reload.
                        if (!ack_phase) begin
                            if (scl_rise) begin
                                if (!sda) begin
                                    REG_ADDR  <= reg_inc(REG_ADDR);
                                    ack_phase <= 1'b1;
                                end else begin
                                    state <= ST_IGNORE;
                                end
                            end
                        end else if (scl_fall) begin
                            RD_STRB   <= 1'b1;
                            state     <= ST_RD_BYTE;
                            bit_cnt   <= 3'd0;
                            ack_phase <= 1'b0;
                        end
                    end
                    ST_IGNORE: SDA_OE <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

endmodule
